// File: rtl/spram_pkg.sv
// Shared types for the single-port RAM arbiter: default widths, requester ids, read tags.
// Read tags travel down the read pipeline so returned data reaches the issuing requester.
package spram_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// Two-way round-robin grant with last-winner register; the loser of a contention wins the next one.
// Latency: grants are combinational in the request cycle; last_gnt updates at the following edge.
// Backpressure: a non-granted requester simply keeps its request up; grants are suppressed during reset.
module rr_arb2
    import spram_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic a_gnt_o,
    output logic b_gnt_o
);

    req_id_e last_gnt_q;
    req_id_e last_gnt_d;

    always_comb begin
        a_gnt_o = 1'b0;
        b_gnt_o = 1'b0;
        if (!rst_i) begin
            if (a_req_i && (!b_req_i || last_gnt_q == REQ_B)) begin
                a_gnt_o = 1'b1;
            end else if (b_req_i) begin
                b_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (a_gnt_o) begin
            last_gnt_d = REQ_A;
        end else if (b_gnt_o) begin
            last_gnt_d = REQ_B;
        end
    end

    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_q <= REQ_B;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between requesters A and B, one access per cycle, round-robin.
// Latency: read grant to rvalid is 2 cycles; writes complete at the grant edge with no response.
// Backpressure: gnt is the only flow control; a requester holds its fields until it sees gnt.
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]  contention_cnt
);

    rd_tag_t           s1_q;
    rd_tag_t           s1_d;
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    rr_arb2 u_arb (
        .clk_i   (clk),
        .rst_i   (rst),
        .a_req_i (a_req),
        .b_req_i (b_req),
        .a_gnt_o (a_gnt),
        .b_gnt_o (b_gnt)
    );

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_data = a_wdata;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_data = b_wdata;
        end
    end

    always_comb begin
        s1_d.valid = (a_gnt && !a_we) || (b_gnt && !b_we);
        s1_d.id    = b_gnt ? REQ_B : REQ_A;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (a_req && b_req && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ram_q is valid the cycle after the read grant; capture it then, pulse rvalid the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            a_rvalid_q <= s1_q.valid && s1_q.id == REQ_A;
            b_rvalid_q <= s1_q.valid && s1_q.id == REQ_B;
            if (s1_q.valid && s1_q.id == REQ_A) begin
                a_rdata_q <= ram_q;
            end
            if (s1_q.valid && s1_q.id == REQ_B) begin
                b_rdata_q <= ram_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign a_rvalid       = a_rvalid_q;
    assign b_rvalid       = b_rvalid_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign contention_cnt = cnt_q;

endmodule
